// File: rtl/lvds_video_timing_gen_pkg.sv
// Shared definitions for the LVDS raster / test-pattern source: pattern codes,
// default 1366x768 panel timing and the serdes datain word layout.
package lvds_video_timing_gen_pkg;

    typedef enum logic [2:0] {
        PAT_BLACK  = 3'd0,
        PAT_BARS   = 3'd1,
        PAT_HGRAD  = 3'd2,
        PAT_GRID   = 3'd3,
        PAT_SOLID  = 3'd4,
        PAT_SCROLL = 3'd5
    } pat_e;

    // Default panel: 1366x768, totals 1540 x 780.
    localparam int DEF_H_ACTIVE    = 1366;
    localparam int DEF_H_FP        = 14;
    localparam int DEF_H_SYNC      = 56;
    localparam int DEF_H_BP        = 104;
    localparam int DEF_V_ACTIVE    = 768;
    localparam int DEF_V_FP        = 3;
    localparam int DEF_V_SYNC      = 5;
    localparam int DEF_V_BP        = 4;
    localparam bit DEF_SYNC_ACTIVE = 1'b0;
    localparam int DEF_COLOR_W     = 6;
    localparam int DEF_GRID_LOG2   = 5;
    localparam int DEF_CNT_W       = 11;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // video_data layout, MSB first: {hsync, vsync, data_en, green, red, blue}.
    localparam int VD_CTRL_BITS = 3;

    // Colour-bar channel enables as {r, g, b}:
    // white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb_mask(input logic [2:0] bar);
        logic [2:0] mask;
        case (bar)
            3'd0:    mask = 3'b111;
            3'd1:    mask = 3'b110;
            3'd2:    mask = 3'b011;
            3'd3:    mask = 3'b010;
            3'd4:    mask = 3'b101;
            3'd5:    mask = 3'b100;
            3'd6:    mask = 3'b001;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern function: maps a raster coordinate plus the
// frame's latched mode, solid colour and scroll offset to a {g,r,b} pixel.
module video_pattern_gen
    import lvds_video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int GRID_LOG2 = DEF_GRID_LOG2,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic [CNT_W-1:0]     h,
    input  logic [CNT_W-1:0]     v,
    input  logic [2:0]           mode,
    input  logic [3*COLOR_W-1:0] solid,
    input  logic [COLOR_W-1:0]   frame_cnt,
    output logic [3*COLOR_W-1:0] rgb
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

    logic [2:0]         bar_idx;
    logic [2:0]         bar_mask;
    logic [COLOR_W-1:0] ramp;
    logic [COLOR_W-1:0] scroll_red;
    logic               grid_on;

    // Thresholds are constants; bars past the seventh fall into the last bar,
    // which therefore absorbs the H_ACTIVE/8 remainder.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h >= CNT_W'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    assign bar_mask   = bar_rgb_mask(bar_idx);
    assign ramp       = h[COLOR_W+1:2];
    assign scroll_red = ramp + frame_cnt;
    assign grid_on    = (h[GRID_LOG2-1:0] == '0) || (v[GRID_LOG2-1:0] == '0) ||
                        (h == H_LAST_ACT) || (v == V_LAST_ACT);

    always_comb begin
        rgb = '0;
        case (mode)
            PAT_BARS:   rgb = {{COLOR_W{bar_mask[1]}}, {COLOR_W{bar_mask[2]}},
                               {COLOR_W{bar_mask[0]}}};
            PAT_HGRAD:  rgb = {ramp, ramp, ramp};
            PAT_GRID:   rgb = {(3*COLOR_W){grid_on}};
            PAT_SOLID:  rgb = solid;
            PAT_SCROLL: rgb = {{COLOR_W{1'b0}}, scroll_red, {COLOR_W{1'b0}}};
            default:    rgb = '0;
        endcase
    end

endmodule

// File: rtl/lvds_video_timing_gen.sv
// Raster timing and test-pattern source feeding the 7:1 LVDS serdes datain bus;
// counters, sync decode, per-frame pattern latch and one aligned output stage.
module lvds_video_timing_gen
    import lvds_video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int GRID_LOG2   = DEF_GRID_LOG2,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                          pixel_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [2:0]                    pattern_sel,
    input  logic [3*COLOR_W-1:0]          solid_rgb,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          data_en,
    output logic [COLOR_W-1:0]            red,
    output logic [COLOR_W-1:0]            green,
    output logic [COLOR_W-1:0]            blue,
    output logic [3*COLOR_W+VD_CTRL_BITS-1:0] video_data,
    output logic                          frame_start,
    output logic                          line_start,
    output logic [CNT_W-1:0]              pos_x,
    output logic [CNT_W-1:0]              pos_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]     h_cnt;
    logic [CNT_W-1:0]     v_cnt;
    logic                 at_origin;
    logic                 h_wrap;
    logic                 hs_win;
    logic                 vs_win;
    logic                 de_win;

    logic [2:0]           mode_q;
    logic [2:0]           mode_eff;
    logic [3*COLOR_W-1:0] solid_q;
    logic [3*COLOR_W-1:0] solid_eff;
    logic [COLOR_W-1:0]   frame_cnt;
    logic [COLOR_W-1:0]   scroll_q;
    logic [COLOR_W-1:0]   scroll_eff;
    logic [3*COLOR_W-1:0] pat_rgb;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign h_wrap    = (h_cnt == H_LAST);

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Mode, colour and scroll offset are captured at (0,0); the origin pixel
    // bypasses the capture so it already belongs to the new frame.
    always_comb begin
        mode_eff   = mode_q;
        solid_eff  = solid_q;
        scroll_eff = scroll_q;
        if (at_origin) begin
            mode_eff   = pattern_sel;
            solid_eff  = solid_rgb;
            scroll_eff = frame_cnt;
        end
    end

    // frame_cnt counts frame starts since rst only; enable does not clear it.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            mode_q    <= PAT_BLACK;
            solid_q   <= '0;
            scroll_q  <= '0;
            frame_cnt <= '0;
        end else if (enable && at_origin) begin
            mode_q    <= pattern_sel;
            solid_q   <= solid_rgb;
            scroll_q  <= frame_cnt;
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    video_pattern_gen #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .COLOR_W   (COLOR_W),
        .GRID_LOG2 (GRID_LOG2),
        .CNT_W     (CNT_W)
    ) u_pattern (
        .h         (h_cnt),
        .v         (v_cnt),
        .mode      (mode_eff),
        .solid     (solid_eff),
        .frame_cnt (scroll_eff),
        .rgb       (pat_rgb)
    );

    assign hs_win = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_win = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign de_win = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            data_en     <= 1'b0;
            green       <= '0;
            red         <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
        end else if (!enable) begin
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            data_en     <= 1'b0;
            green       <= '0;
            red         <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
        end else begin
            hsync              <= hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync              <= vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            data_en            <= de_win;
            {green, red, blue} <= de_win ? pat_rgb : '0;
            frame_start        <= at_origin;
            line_start         <= (h_cnt == '0);
            pos_x              <= h_cnt;
            pos_y              <= v_cnt;
        end
    end

    assign video_data = {hsync, vsync, data_en, green, red, blue};

endmodule

// File: tb/tb_lvds_video_timing_gen.sv
// Directed-plus-random bench for lvds_video_timing_gen on a reduced raster
// (43x6 active, 55x10 total) so many whole frames fit in a short run.
module tb_lvds_video_timing_gen;
  localparam int HA = 43;
  localparam int HFP = 3;
  localparam int HS = 5;
  localparam int HBP = 4;
  localparam int VA = 6;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int BAR_W = HA / 8;
  localparam int FRAME = HT * VT;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [2:0] pattern_sel = 3'd0;
  logic [17:0] solid_rgb = 18'd0;
  logic hsync, vsync, data_en, frame_start, line_start;
  logic [5:0] red, green, blue;
  logic [20:0] video_data;
  logic [7:0] pos_x, pos_y;

  int total = 0;
  int bad = 0;

  // reference model state: raster position, per-frame latches, frame count
  int m_h = 0, m_v = 0, m_mode = 0, m_fc = 0, m_off = 0;
  logic [17:0] m_solid = 18'd0;
  int e_px = 0, e_py = 0;
  logic e_act = 1'b0;

  lvds_video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACTIVE(1'b0), .COLOR_W(6), .GRID_LOG2(2), .CNT_W(8)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .data_en(data_en),
    .red(red), .green(green), .blue(blue), .video_data(video_data),
    .frame_start(frame_start), .line_start(line_start),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel value from the pattern rules, returned as {g,r,b}.
  function automatic logic [17:0] model_rgb(input int x, input int y, input int mode,
                                            input logic [17:0] sol, input int off);
    int bar, r, g, b, ramp;
    r = 0; g = 0; b = 0;
    if (x >= HA || y >= VA) return 18'd0;
    ramp = (x / 4) % 64;
    case (mode)
      1: begin
        bar = x / BAR_W;
        if (bar > 7) bar = 7;
        r = ((bar / 2) % 2 == 0) ? 63 : 0;
        g = (bar < 4) ? 63 : 0;
        b = (bar % 2 == 0) ? 63 : 0;
      end
      2: begin r = ramp; g = ramp; b = ramp; end
      3: begin
        if (x % 4 == 0 || y % 4 == 0 || x == HA - 1 || y == VA - 1) begin
          r = 63; g = 63; b = 63;
        end
      end
      4: return sol;
      5: r = (ramp + off) % 64;
      default: ;
    endcase
    return {6'(g), 6'(r), 6'(b)};
  endfunction

  function automatic logic [59:0] pack(input logic hs, input logic vs, input logic de,
                                       input logic [17:0] grb, input logic fs, input logic ls,
                                       input logic [7:0] px, input logic [7:0] py);
    return {hs, vs, de, grb[11:6], grb[17:12], grb[5:0], fs, ls, px, py, hs, vs, de, grb};
  endfunction

  function automatic logic [59:0] observed();
    return {hsync, vsync, data_en, red, green, blue, frame_start, line_start,
            pos_x, pos_y, video_data};
  endfunction

  task automatic reset_model();
    m_h = 0; m_v = 0; m_mode = 0; m_fc = 0; m_off = 0; m_solid = 18'd0;
  endtask

  // One pixel clock: predict the outputs from the inputs seen at the edge,
  // then compare everything at the following falling edge.
  task automatic step();
    logic ehs, evs, ede, efs, els;
    logic [17:0] egrb;
    logic [7:0] epx, epy;
    @(posedge pixel_clk);
    e_act = enable;
    if (enable) begin
      if (m_h == 0 && m_v == 0) begin
        m_mode = int'(pattern_sel);
        m_solid = solid_rgb;
        m_off = m_fc % 64;
        m_fc++;
      end
      ehs = !(m_h >= HA + HFP && m_h < HA + HFP + HS);
      evs = !(m_v >= VA + VFP && m_v < VA + VFP + VS);
      ede = (m_h < HA) && (m_v < VA);
      egrb = model_rgb(m_h, m_v, m_mode, m_solid, m_off);
      efs = (m_h == 0 && m_v == 0);
      els = (m_h == 0);
      epx = 8'(m_h);
      epy = 8'(m_v);
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end else begin
      ehs = 1'b1; evs = 1'b1; ede = 1'b0; egrb = 18'd0; efs = 1'b0; els = 1'b0;
      epx = 8'd0; epy = 8'd0;
      m_h = 0; m_v = 0;
    end
    e_px = int'(epx);
    e_py = int'(epy);
    @(negedge pixel_clk);
    check($sformatf("pixel(%0d,%0d)", e_px, e_py), 64'(observed()),
          64'(pack(ehs, evs, ede, egrb, efs, els, epx, epy)));
  endtask

  task automatic run_to(input int x, input int y);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(e_act && e_px == x && e_py == y) && n < 2 * FRAME);
    check($sformatf("run_to(%0d,%0d)", x, y), 64'(n >= 2 * FRAME), 64'(0));
  endtask

  initial begin
    int fs_idx, fs_gap, ls_idx, ls_gap, fs_cnt, ls_cnt, de_cnt, de_line0;
    int hs_cnt0, hs_first, vs_lines, vs_first;
    logic [17:0] p0, p5, p35, p42, p43;
    fs_idx = -1; fs_gap = -1; ls_idx = -1; ls_gap = -1; fs_cnt = 0; ls_cnt = 0;
    de_cnt = 0; de_line0 = 0; hs_cnt0 = 0; hs_first = -1; vs_lines = 0; vs_first = -1;
    p0 = '1; p5 = '1; p35 = '1; p42 = '1; p43 = '1;

    // reset state and idle while enable is low
    repeat (3) @(negedge pixel_clk);
    check("reset", 64'(observed()), 64'(pack(1, 1, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    reset_model();
    repeat (3) step();

    // colour bars: raster timing and bar values over one full frame
    pattern_sel = 3'd1;
    enable = 1'b1;
    for (int i = 0; i <= FRAME; i++) begin
      step();
      if (frame_start) begin
        if (fs_idx < 0) fs_idx = i; else if (fs_gap < 0) fs_gap = i - fs_idx;
      end
      if (line_start) begin
        if (ls_idx < 0) ls_idx = i; else if (ls_gap < 0) ls_gap = i - ls_idx;
      end
      if (i < FRAME) begin
        if (frame_start) fs_cnt++;
        if (line_start) ls_cnt++;
        if (data_en) de_cnt++;
        if (line_start && vsync == 1'b0) begin
          vs_lines++;
          if (vs_first < 0) vs_first = int'(pos_y);
        end
        if (pos_y == 8'd0) begin
          if (data_en) de_line0++;
          if (hsync == 1'b0) begin
            hs_cnt0++;
            if (hs_first < 0) hs_first = int'(pos_x);
          end
          if (pos_x == 8'd0) p0 = {red, green, blue};
          if (pos_x == 8'd5) p5 = {red, green, blue};
          if (pos_x == 8'd35) p35 = {red, green, blue};
          if (pos_x == 8'd42) p42 = {red, green, blue};
          if (pos_x == 8'd43) p43 = {red, green, blue};
        end
      end
    end
    check("hs_start", 64'(hs_first), 64'(HA + HFP));
    check("hs_width", 64'(hs_cnt0), 64'(HS));
    check("line_period", 64'(ls_gap), 64'(HT));
    check("frame_period", 64'(fs_gap), 64'(FRAME));
    check("lines_per_frame", 64'(ls_cnt), 64'(VT));
    check("fs_per_frame", 64'(fs_cnt), 64'(1));
    check("vs_first_line", 64'(vs_first), 64'(VA + VFP));
    check("vs_lines", 64'(vs_lines), 64'(VS));
    check("de_line0", 64'(de_line0), 64'(HA));
    check("de_frame", 64'(de_cnt), 64'(HA * VA));
    check("bar_px0", 64'(p0), 64'({6'd63, 6'd63, 6'd63}));
    check("bar_px5", 64'(p5), 64'({6'd63, 6'd63, 6'd0}));
    check("bar_px35", 64'(p35), 64'(0));
    check("bar_px42", 64'(p42), 64'(0));
    check("bar_px43", 64'(p43), 64'(0));

    // mid-frame switch to solid: bars hold until the next frame
    run_to(20, 3);
    pattern_sel = 3'd4;
    solid_rgb = {6'd10, 6'd20, 6'd30};
    run_to(0, 4);
    check("bars_hold", 64'({red, green, blue}), 64'({6'd63, 6'd63, 6'd63}));
    run_to(0, 0);
    check("solid_next", 64'({red, green, blue}), 64'({6'd20, 6'd10, 6'd30}));

    // enable drop mid-line, then re-enable
    run_to(10, 2);
    enable = 1'b0;
    step();
    check("blank_de", 64'(data_en), 64'(0));
    check("blank_sync", 64'({hsync, vsync}), 64'(2'b11));
    enable = 1'b1;
    step();
    check("reen_origin", 64'({frame_start, line_start, pos_x, pos_y}), 64'({2'b11, 16'd0}));

    // randomized pattern / colour / enable traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) pattern_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3) solid_rgb = 18'($urandom);
      if (enable && $urandom_range(0, 1499) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      step();
    end
    enable = 1'b1;
    step();

    // asynchronous reset mid-frame, checked before any clock edge
    run_to(20, 3);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 3'd5;
    #1;
    check("async_rst", 64'(observed()), 64'(pack(1, 1, 0, 0, 0, 0, 0, 0)));
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1'b0;
    reset_model();
    step();

    // scrolling red: offset follows frames since reset and wraps after 63
    enable = 1'b1;
    for (int f = 0; f <= 64; f++) begin
      run_to(0, 0);
      if (f < 3 || f >= 63) check($sformatf("scroll_f%0d", f), 64'(red), 64'(f % 64));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
